q_sys_descriptor_walker: RTL and testbench
==========================================

# q_sys_descriptor_walker

Avalon-MM read/write master that walks a linked list of 8-word descriptors stored in the on-chip descriptor memory. It emits each hardware-owned descriptor's words on a valid/ready stream for the DMA datapath. After the last word is consumed, it clears the descriptor's ownership bit in memory and follows the next pointer. It connects to the descriptor memory's slave port, which has no waitrequest and 1-cycle read latency, and tolerates waitrequest for fabric insertion.

## Interface
- ADDR_W, 11, word-address width of the descriptor memory.
- DESC_WORDS, 8, words per descriptor; word 4 = next pointer (byte address), word 7 = control (bit 31 = OWNED_BY_HW).
- clk  in  1  system clock; all logic rising-edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse; sampled only in IDLE.
- head_ptr  in  ADDR_W  word address of the first descriptor; latched on start.
- stop  in  1  level; ends the walk at the next descriptor boundary.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the walk ends.
- desc_count  out  16  descriptors completed since the last start; saturates at 0xFFFF.
- m_address  out  ADDR_W  word address.
- m_read / m_write  out  1  read and write strobes; never both high.
- m_byteenable  out  4  4'b1111 on reads, 4'b1000 on writeback.
- m_writedata  out  32  writeback data.
- m_readdata  in  32  valid exactly 1 cycle after an accepted read.
- m_waitrequest  in  1  a command is accepted only when this is low; tie to 0 for the descriptor memory.
- out_data  out  32  descriptor word.
- out_valid / out_ready  out / in  1  stream handshake; transfer occurs when both are high.
- out_sop / out_eop  out  1  mark word 0 and word DESC_WORDS-1.

## Operation
- States and transitions:
  - IDLE → RD_CTRL on start; clears desc_count and loads cur_ptr from head_ptr.
  - RD_CTRL holds m_read at cur_ptr+7 until accepted, then → WAIT_CTRL.
  - WAIT_CTRL latches ctrl.
    - If ctrl[31]=0 or stop=1 → DONE.
    - Otherwise word index ← 0 and → RD_WORD.
  - RD_WORD is entered only while the output register is empty. It holds m_read at cur_ptr+index until accepted, then → WAIT_WORD.
  - WAIT_WORD loads readdata into the output register and sets out_valid. Word 4 is also latched as nxt.
    - If index < DESC_WORDS-1: index+1 → HOLD.
    - Else → HOLD_LAST.
  - HOLD / HOLD_LAST wait for the out_valid·out_ready transfer.
    - HOLD → RD_WORD after the transfer.
    - HOLD_LAST → WB_CTRL after the transfer.
  - WB_CTRL holds the write until accepted, then → NEXT. The write drives address cur_ptr+7, writedata {1'b0, ctrl[30:0]}, byteenable 4'b1000.
  - NEXT: desc_count+1 (saturating); cur_ptr ← nxt[ADDR_W+1:2]; → RD_CTRL, or → DONE if stop=1.
  - DONE: pulse done for one cycle → IDLE.
- Address arithmetic is modulo 2^ADDR_W; a descriptor that straddles the top of memory wraps to 0.
- Loop detection is not performed; a circular list runs until stop is asserted.
- Control word 7 is read twice: once in WAIT_CTRL and again as the eop word. The stream carries the second value.
- start while busy is ignored. stop asserted while in IDLE has no effect.

## Timing
- Reset values: busy=0, done=0, desc_count=0, m_read=0, m_write=0, m_address=0, m_byteenable=0, m_writedata=0, out_valid=0, out_sop=0, out_eop=0, out_data=0; state=IDLE.
- Reset mid-walk: the next cycle is IDLE with all outputs at reset values. An in-flight read result is discarded; a pending writeback is not issued.
- With start at cycle 0 and m_waitrequest=0:
  - cycle 1: m_read asserted.
  - cycle 2: WAIT_CTRL.
  - cycle 3: RD_WORD for word 0.
  - cycle 4: WAIT_WORD.
  - cycle 5: out_valid=1 with out_sop=1.
- With out_ready tied high, one word is delivered every 3 cycles.
- m_address and m_byteenable are stable while the strobe is held under waitrequest.
- out_data, out_sop, and out_eop are stable while out_valid=1 and out_ready=0.
- done is high for exactly one cycle. busy falls in the cycle after done.

## Test plan
- Single descriptor:
  - Stimulus: at word 0x040, words 0..7 = 0x1000, 0, 0x2000, 0, 0x0, 0, 0x40, 0x80000000; word 0x000 control = 0. Start with head_ptr=0x040.
  - Response: 8 stream words in order, sop on 0x1000, eop on 0x80000000. Write to 0x047 with data 0x00000000 and byteenable 4'b1000. done asserted; desc_count=1.
- Chain of 3:
  - Stimulus: descriptors at 0x000→0x010→0x020 via byte pointers 0x40 and 0x80; a fourth descriptor at 0x030 has ctrl=0.
  - Response: 24 words, 3 writebacks, desc_count=3, 0x030 never streamed.
- Head not owned:
  - Stimulus: ctrl[31]=0 at head.
  - Response: one read at head+7, no stream words, no writes; done in cycle 3; desc_count=0.
- Backpressure and waitrequest:
  - Stimulus: out_ready toggles at random; m_waitrequest high for 3 cycles on every command.
  - Response: identical word sequence; no duplicated or dropped words; address stable while stalled.
- stop mid-descriptor:
  - Stimulus: assert stop during word 3 of descriptor 1 of a 3-chain.
  - Response: descriptor 1 completes with its writeback, then done; desc_count=1.
- Reset mid-walk and wrap:
  - Stimulus: assert reset during WAIT_WORD. Then run a descriptor at 0x7FC.
  - Response: all outputs return to reset values the next cycle and no write is issued. The descriptor at 0x7FC reads 0x7FC..0x7FF, 0x000..0x003 and writes back to 0x003.

Source files
------------

// File: rtl/q_sys_descriptor_walker.sv
// rtl/q_sys_descriptor_walker.sv - linked-list descriptor walker streaming owned descriptors
//
// Walks a linked list of DESC_WORDS-word descriptors through an Avalon-MM master.
// Each hardware-owned descriptor is streamed word by word, and its control word is
// then written back with the ownership bit cleared.
//
// Ports:
//   clk, reset         rising-edge clock, synchronous active-high reset
//   start, head_ptr    begin a walk at word address head_ptr (accepted only in IDLE)
//   stop               level; ends the walk at the next descriptor boundary
//   busy, done         walk in progress / one-cycle completion pulse
//   desc_count         descriptors completed since the last start (saturating)
//   m_*                Avalon-MM master (word addressed, 1-cycle read latency)
//   out_*              descriptor word stream with sop/eop framing
module q_sys_descriptor_walker #(
    parameter int ADDR_W     = 11,
    parameter int DESC_WORDS = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] head_ptr,
    input  logic              stop,
    output logic              busy,
    output logic              done,
    output logic [15:0]       desc_count,
    output logic [ADDR_W-1:0] m_address,
    output logic              m_read,
    output logic              m_write,
    output logic [3:0]        m_byteenable,
    output logic [31:0]       m_writedata,
    input  logic [31:0]       m_readdata,
    input  logic              m_waitrequest,
    output logic [31:0]       out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sop,
    output logic              out_eop
);

    localparam int                IDX_W    = $clog2(DESC_WORDS);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DESC_WORDS - 1);
    localparam logic [IDX_W-1:0]  IDX_NEXT = IDX_W'(4);
    localparam logic [ADDR_W-1:0] CTRL_OFS = ADDR_W'(DESC_WORDS - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_RD_CTRL,
        S_WAIT_CTRL,
        S_RD_WORD,
        S_WAIT_WORD,
        S_HOLD,
        S_HOLD_LAST,
        S_WB_CTRL,
        S_NEXT,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cur_ptr_q, cur_ptr_d;
    logic [ADDR_W-1:0] nxt_q, nxt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [30:0]       ctrl_q, ctrl_d;
    logic [15:0]       count_q, count_d;
    logic [31:0]       out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              out_sop_q, out_sop_d;
    logic              out_eop_q, out_eop_d;
    logic              xfer;

    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign desc_count = count_q;
    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign out_sop    = out_sop_q;
    assign out_eop    = out_eop_q;
    assign xfer       = out_valid_q & out_ready;

    always_comb begin
        state_d      = state_q;
        cur_ptr_d    = cur_ptr_q;
        nxt_d        = nxt_q;
        idx_d        = idx_q;
        ctrl_d       = ctrl_q;
        count_d      = count_q;
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;
        out_sop_d    = out_sop_q;
        out_eop_d    = out_eop_q;
        m_read       = 1'b0;
        m_write      = 1'b0;
        m_address    = '0;
        m_byteenable = 4'b0000;
        m_writedata  = 32'h0;

        // Output register empties on handshake; WAIT_WORD below may refill it.
        if (xfer) begin
            out_valid_d = 1'b0;
            out_sop_d   = 1'b0;
            out_eop_d   = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    count_d   = 16'h0;
                    cur_ptr_d = head_ptr;
                    state_d   = S_RD_CTRL;
                end
            end
            S_RD_CTRL: begin
                m_read       = 1'b1;
                m_address    = cur_ptr_q + CTRL_OFS;
                m_byteenable = 4'b1111;
                if (!m_waitrequest) begin
                    state_d = S_WAIT_CTRL;
                end
            end
            S_WAIT_CTRL: begin
                ctrl_d = m_readdata[30:0];
                if (!m_readdata[31] || stop) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = '0;
                    state_d = S_RD_WORD;
                end
            end
            S_RD_WORD: begin
                m_read       = 1'b1;
                m_address    = cur_ptr_q + ADDR_W'(idx_q);
                m_byteenable = 4'b1111;
                if (!m_waitrequest) begin
                    state_d = S_WAIT_WORD;
                end
            end
            S_WAIT_WORD: begin
                out_data_d  = m_readdata;
                out_valid_d = 1'b1;
                out_sop_d   = (idx_q == '0);
                out_eop_d   = (idx_q == IDX_LAST);
                if (idx_q == IDX_NEXT) begin
                    // Next pointer is a byte address; keep only the word address.
                    nxt_d = m_readdata[ADDR_W+1:2];
                end
                if (idx_q < IDX_LAST) begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = S_HOLD;
                end else begin
                    state_d = S_HOLD_LAST;
                end
            end
            S_HOLD: begin
                if (xfer) begin
                    state_d = S_RD_WORD;
                end
            end
            S_HOLD_LAST: begin
                if (xfer) begin
                    state_d = S_WB_CTRL;
                end
            end
            S_WB_CTRL: begin
                // Only the top byte lane is written, so only the ownership byte changes.
                m_write      = 1'b1;
                m_address    = cur_ptr_q + CTRL_OFS;
                m_byteenable = 4'b1000;
                m_writedata  = {1'b0, ctrl_q};
                if (!m_waitrequest) begin
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                if (count_q != 16'hFFFF) begin
                    count_d = count_q + 16'h1;
                end
                cur_ptr_d = nxt_q;
                state_d   = stop ? S_DONE : S_RD_CTRL;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cur_ptr_q   <= '0;
            nxt_q       <= '0;
            idx_q       <= '0;
            ctrl_q      <= '0;
            count_q     <= 16'h0;
            out_data_q  <= 32'h0;
            out_valid_q <= 1'b0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_ptr_q   <= cur_ptr_d;
            nxt_q       <= nxt_d;
            idx_q       <= idx_d;
            ctrl_q      <= ctrl_d;
            count_q     <= count_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_sop_q   <= out_sop_d;
            out_eop_q   <= out_eop_d;
        end
    end

endmodule

// File: tb/tb_q_sys_descriptor_walker.sv
// tb/tb_q_sys_descriptor_walker.sv - self-checking bench for q_sys_descriptor_walker
module tb_q_sys_descriptor_walker;

    localparam int AW  = 11;
    localparam int DW  = 8;
    localparam int MEM = 1 << AW;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] head_ptr;
    logic          stop;
    logic          busy;
    logic          done;
    logic [15:0]   desc_count;
    logic [AW-1:0] m_address;
    logic          m_read;
    logic          m_write;
    logic [3:0]    m_byteenable;
    logic [31:0]   m_writedata;
    logic [31:0]   m_readdata;
    logic          m_waitrequest;
    logic [31:0]   out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_sop;
    logic          out_eop;

    always #5 clk = ~clk;

    q_sys_descriptor_walker #(.ADDR_W(AW), .DESC_WORDS(DW)) dut (
        .clk(clk), .reset(reset), .start(start), .head_ptr(head_ptr), .stop(stop),
        .busy(busy), .done(done), .desc_count(desc_count),
        .m_address(m_address), .m_read(m_read), .m_write(m_write),
        .m_byteenable(m_byteenable), .m_writedata(m_writedata),
        .m_readdata(m_readdata), .m_waitrequest(m_waitrequest),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_sop(out_sop), .out_eop(out_eop)
    );

    logic [31:0]   mem     [0:MEM-1];
    logic [31:0]   ref_mem [0:MEM-1];
    int            n_cmp = 0;
    int            n_bad = 0;
    logic          rnd_ready = 1'b0;
    logic          stall_mode = 1'b0;

    logic [31:0]   got_data [$];
    logic          got_sop  [$];
    logic          got_eop  [$];
    logic [AW-1:0] rd_log   [$];
    logic [AW-1:0] wr_addr_log [$];
    logic [31:0]   wr_data_log [$];
    logic [3:0]    wr_be_log   [$];

    logic [31:0]   exp_data [$];
    logic [AW-1:0] exp_rd   [$];
    logic [AW-1:0] exp_wr_addr [$];
    logic [31:0]   exp_wr_data [$];
    int            exp_count;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Memory slave and stream sink, all activity on the falling edge.
    logic          pend_rd;
    logic [AW-1:0] pend_addr;
    int            stall_cnt;
    logic          prev_stall, p_rd, p_wr, prev_hold, h_sop, h_eop;
    logic [AW-1:0] p_addr;
    logic [3:0]    p_be;
    logic [31:0]   p_wd, h_data;

    initial begin
        pend_rd = 1'b0; pend_addr = '0; stall_cnt = 0;
        prev_stall = 1'b0; prev_hold = 1'b0;
        m_readdata = 32'h0; m_waitrequest = 1'b0; out_ready = 1'b0;
        forever begin
            @(negedge clk);
            m_readdata = pend_rd ? mem[pend_addr] : $urandom;
            pend_rd = 1'b0;
            out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (reset) begin
                prev_stall = 1'b0; prev_hold = 1'b0; stall_cnt = 0; m_waitrequest = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("stall_addr", 32'(m_address), 32'(p_addr));
                    chk("stall_be", 32'(m_byteenable), 32'(p_be));
                    chk("stall_strobe", {30'h0, m_read, m_write}, {30'h0, p_rd, p_wr});
                    if (p_wr) chk("stall_wdata", m_writedata, p_wd);
                end
                if (m_read || m_write) begin
                    chk("rd_wr_exclusive", 32'(m_read & m_write), 32'h0);
                    if (stall_mode && stall_cnt < 3) begin
                        m_waitrequest = 1'b1; stall_cnt++;
                    end else begin
                        m_waitrequest = 1'b0; stall_cnt = 0;
                    end
                end else begin
                    m_waitrequest = 1'b0;
                end
                prev_stall = (m_read || m_write) && m_waitrequest;
                p_addr = m_address; p_be = m_byteenable; p_rd = m_read; p_wr = m_write; p_wd = m_writedata;
                if ((m_read || m_write) && !m_waitrequest) begin
                    if (m_read) begin
                        chk("read_be", 32'(m_byteenable), 32'hF);
                        pend_rd = 1'b1; pend_addr = m_address;
                        rd_log.push_back(m_address);
                    end else begin
                        for (int b = 0; b < 4; b++)
                            if (m_byteenable[b]) mem[m_address][8*b +: 8] = m_writedata[8*b +: 8];
                        wr_addr_log.push_back(m_address);
                        wr_data_log.push_back(m_writedata);
                        wr_be_log.push_back(m_byteenable);
                    end
                end
                if (prev_hold) begin
                    chk("hold_data", out_data, h_data);
                    chk("hold_sop_eop", {30'h0, out_sop, out_eop}, {30'h0, h_sop, h_eop});
                end
                if (out_valid && out_ready) begin
                    got_data.push_back(out_data);
                    got_sop.push_back(out_sop);
                    got_eop.push_back(out_eop);
                end
                prev_hold = out_valid && !out_ready;
                h_data = out_data; h_sop = out_sop; h_eop = out_eop;
            end
        end
    end

    // Reference walk over a copy of memory; max_desc < 0 means no stop.
    task automatic build_expect(input logic [AW-1:0] head, input int max_desc);
        logic [AW-1:0] p, a;
        logic [31:0]   c, nx;
        exp_data.delete(); exp_rd.delete(); exp_wr_addr.delete(); exp_wr_data.delete();
        exp_count = 0;
        for (int i = 0; i < MEM; i++) ref_mem[i] = mem[i];
        p = head;
        for (int d = 0; d < 64; d++) begin
            if (exp_count == max_desc) break;
            a = p + AW'(DW - 1);
            c = ref_mem[a];
            exp_rd.push_back(a);
            if (!c[31]) break;
            for (int i = 0; i < DW; i++) begin
                a = p + AW'(i);
                exp_rd.push_back(a);
                exp_data.push_back(ref_mem[a]);
            end
            a = p + AW'(DW - 1);
            exp_wr_addr.push_back(a);
            exp_wr_data.push_back({1'b0, c[30:0]});
            ref_mem[a] = {1'b0, c[30:0]};
            exp_count++;
            a = p + AW'(4);
            nx = ref_mem[a];
            p = nx[AW+1:2];
        end
    endtask

    task automatic clear_logs();
        got_data.delete(); got_sop.delete(); got_eop.delete();
        rd_log.delete(); wr_addr_log.delete(); wr_data_log.delete(); wr_be_log.delete();
    endtask

    task automatic do_walk(input string tag, input logic [AW-1:0] head, input int max_desc,
                           input int stop_at, input int exp_done_cyc, input bit timing);
        int cyc;
        bit seen;
        build_expect(head, max_desc);
        clear_logs();
        head_ptr = head;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        head_ptr = AW'($urandom);
        cyc = 1;
        seen = 1'b0;
        while (cyc < 20000) begin
            if (timing && cyc == 1) begin
                chk({tag, "_c1_read"}, 32'(m_read), 32'h1);
                chk({tag, "_c1_addr"}, 32'(m_address), 32'(AW'(head + AW'(7))));
            end
            if (timing && cyc == 5)
                chk({tag, "_c5_valid_sop"}, {30'h0, out_valid, out_sop}, 32'h3);
            if (stop_at >= 0 && got_data.size() >= stop_at) stop = 1'b1;
            if (done) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_done_seen"}, 32'(seen), 32'h1);
        if (exp_done_cyc >= 0) chk({tag, "_done_cycle"}, 32'(cyc), 32'(exp_done_cyc));
        chk({tag, "_busy_at_done"}, 32'(busy), 32'h1);
        @(negedge clk);
        chk({tag, "_after_done"}, {30'h0, busy, done}, 32'h0);
        stop = 1'b0;
        chk({tag, "_desc_count"}, 32'(desc_count), 32'(exp_count));
        chk({tag, "_n_words"}, 32'(got_data.size()), 32'(exp_data.size()));
        for (int i = 0; i < got_data.size() && i < exp_data.size(); i++) begin
            chk($sformatf("%s_word%0d", tag, i), got_data[i], exp_data[i]);
            chk($sformatf("%s_frame%0d", tag, i), {30'h0, got_sop[i], got_eop[i]},
                {30'h0, (i % DW) == 0, (i % DW) == DW - 1});
        end
        chk({tag, "_n_reads"}, 32'(rd_log.size()), 32'(exp_rd.size()));
        for (int i = 0; i < rd_log.size() && i < exp_rd.size(); i++)
            chk($sformatf("%s_rdaddr%0d", tag, i), 32'(rd_log[i]), 32'(exp_rd[i]));
        chk({tag, "_n_writes"}, 32'(wr_addr_log.size()), 32'(exp_wr_addr.size()));
        for (int i = 0; i < wr_addr_log.size() && i < exp_wr_addr.size(); i++) begin
            chk($sformatf("%s_wraddr%0d", tag, i), 32'(wr_addr_log[i]), 32'(exp_wr_addr[i]));
            chk($sformatf("%s_wrdata%0d", tag, i), wr_data_log[i], exp_wr_data[i]);
            chk($sformatf("%s_wrbe%0d", tag, i), 32'(wr_be_log[i]), 32'h8);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy_done"}, {30'h0, busy, done}, 32'h0);
        chk({tag, "_count"}, 32'(desc_count), 32'h0);
        chk({tag, "_strobes"}, {30'h0, m_read, m_write}, 32'h0);
        chk({tag, "_addr"}, 32'(m_address), 32'h0);
        chk({tag, "_be"}, 32'(m_byteenable), 32'h0);
        chk({tag, "_wdata"}, m_writedata, 32'h0);
        chk({tag, "_stream_ctl"}, {29'h0, out_valid, out_sop, out_eop}, 32'h0);
        chk({tag, "_out_data"}, out_data, 32'h0);
    endtask

    task automatic setup_single();
        mem[11'h040] = 32'h1000; mem[11'h041] = 32'h0; mem[11'h042] = 32'h2000;
        mem[11'h043] = 32'h0;    mem[11'h044] = 32'h0; mem[11'h045] = 32'h0;
        mem[11'h046] = 32'h40;   mem[11'h047] = 32'h8000_0000;
        mem[11'h007] = 32'h0;
    endtask

    task automatic setup_chain3();
        logic [AW-1:0] b;
        for (int k = 0; k < 3; k++) begin
            b = AW'(k * 16);
            for (int i = 0; i < DW; i++) mem[b + AW'(i)] = $urandom;
            mem[b + AW'(4)] = 32'((k + 1) * 64);
            mem[b + AW'(7)] = 32'h8000_0000 | $urandom;
        end
        mem[11'h037] = $urandom & 32'h7FFF_FFFF;
    endtask

    initial begin
        logic [AW-1:0] slot, nslot, base;
        int            n;
        reset = 1'b1; start = 1'b0; stop = 1'b0; head_ptr = '0;
        for (int i = 0; i < MEM; i++) mem[i] = $urandom;
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        reset = 1'b0;
        @(negedge clk);

        // Single descriptor with fixed contents and cycle-exact timing.
        setup_single();
        do_walk("single", 11'h040, -1, -1, 31, 1'b1);
        chk("single_wb_addr", 32'(wr_addr_log.size() > 0 ? wr_addr_log[0] : AW'(0)), 32'h047);
        chk("single_wb_data", wr_data_log.size() > 0 ? wr_data_log[0] : 32'hFFFF_FFFF, 32'h0);

        // Three-descriptor chain ending at an unowned descriptor at 0x030.
        setup_chain3();
        do_walk("chain3", 11'h000, -1, -1, -1, 1'b0);

        // Head not owned: one control read then done in cycle 3.
        mem[11'h207] = $urandom & 32'h7FFF_FFFF;
        do_walk("unowned", 11'h200, -1, -1, 3, 1'b0);

        // Random chains under random backpressure and waitrequest stalls.
        for (int t = 0; t < 4; t++) begin
            stall_mode = 1'b1;
            rnd_ready  = 1'b1;
            n    = $urandom_range(1, 4);
            slot = AW'($urandom_range(0, 255));
            for (int k = 0; k <= n; k++) begin
                base  = AW'((32'(slot) + 32'(k) * 37) % 256 * 8);
                nslot = AW'((32'(slot) + 32'(k + 1) * 37) % 256);
                for (int i = 0; i < DW; i++) mem[base + AW'(i)] = $urandom;
                mem[base + AW'(4)] = 32'(nslot) * 32;
                mem[base + AW'(7)] = (k < n) ? (32'h8000_0000 | $urandom) : ($urandom & 32'h7FFF_FFFF);
            end
            do_walk($sformatf("rnd%0d", t), AW'(32'(slot) * 8), -1, -1, -1, 1'b0);
        end
        stall_mode = 1'b0;
        rnd_ready  = 1'b0;

        // stop raised during word 3 of the first descriptor.
        setup_chain3();
        do_walk("stop", 11'h000, 1, 3, -1, 1'b0);

        // Reset during WAIT_WORD of word 0 (cycle 4).
        setup_single();
        clear_logs();
        head_ptr = 11'h040;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_reset_outputs("midreset");
        reset = 1'b0;
        repeat (30) @(negedge clk);
        chk("midreset_no_write", 32'(wr_addr_log.size()), 32'h0);
        chk("midreset_no_words", 32'(got_data.size()), 32'h0);
        chk("midreset_idle", 32'(busy), 32'h0);

        // Descriptor straddling the top of memory.
        for (int i = 0; i < DW; i++) mem[AW'(11'h7FC + AW'(i))] = $urandom;
        mem[11'h000] = 32'h400;
        mem[11'h003] = 32'h8000_0000 | $urandom;
        mem[11'h107] = 32'h0;
        do_walk("wrap", 11'h7FC, -1, -1, -1, 1'b0);
        chk("wrap_wb_addr", 32'(wr_addr_log.size() > 0 ? wr_addr_log[0] : AW'(0)), 32'h003);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
